// File: rtl/memory_nrw_wb.sv
// rtl/memory_nrw_wb.sv - multi-port Wishbone pipelined RAM, read-first, optional bounds check (MEM_BOUNDS_CHECK_EN)
module memory_nrw_wb #(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic [NUM_PORTS-1:0]              wb_cyc_i,
    input  logic [NUM_PORTS-1:0]              wb_stb_i,
    input  logic [NUM_PORTS-1:0]              wb_we_i,
    input  logic [NUM_PORTS*32-1:0]           wb_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [NUM_PORTS-1:0]              wb_stall_o,
    output logic [NUM_PORTS-1:0]              wb_ack_o,
    output logic [NUM_PORTS-1:0]              wb_err_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   wb_dat_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int TOP   = OFFS + ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] idx_all;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] wreq;
    logic [NUM_PORTS-1:0] oob;
    logic [NUM_PORTS-1:0] stall;
    logic [NUM_PORTS-1:0] accept;

    // Write collision arbitration: lowest-index port writing a word wins, later ports wait
    always_comb begin
        stall = '0;
        for (int p = 1; p < NUM_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (wreq[p] && wreq[q] && (idx_all[p] == idx_all[q])) begin
                    stall[p] = 1'b1;
                end
            end
        end
    end

    assign accept     = req & ~stall;
    assign wb_stall_o = stall & {NUM_PORTS{wb_rst_ni}};

    // Byte-masked writes from every accepted port; collisions are already stalled away
    always_ff @(posedge wb_clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p] && wb_we_i[p] && !oob[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wb_sel_i[p*BYTES+b]) begin
                        mem[idx_all[p]][8*b +: 8] <= wb_dat_i[p*DATA_WIDTH + 8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [31:0]           adr;
        logic                  ack1;
        logic                  err1;
        logic [DATA_WIDTH-1:0] rd1;

        assign adr        = wb_adr_i[32*p +: 32];
        assign idx_all[p] = adr[OFFS +: ADDR_WIDTH];
        assign req[p]     = wb_cyc_i[p] & wb_stb_i[p];
        assign wreq[p]    = req[p] & wb_we_i[p];
`ifdef MEM_BOUNDS_CHECK_EN
        assign oob[p]     = (adr >> TOP) != 32'd0;
`else
        assign oob[p]     = 1'b0;
`endif

        // First response stage: ack/err and read-first data captured at the accepting edge
        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                ack1 <= 1'b0;
                err1 <= 1'b0;
                rd1  <= '0;
            end else begin
                if (!wb_cyc_i[p]) begin
                    ack1 <= 1'b0;
                    err1 <= 1'b0;
                end else begin
                    ack1 <= accept[p] & ~oob[p];
                    err1 <= accept[p] & oob[p];
                end
                if (accept[p] && !wb_we_i[p] && !oob[p]) begin
                    rd1 <= mem[idx_all[p]];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rdv1;
            logic                  ack2;
            logic                  err2;
            logic [DATA_WIDTH-1:0] rd2;

            // Second response stage: one extra register, cancelled by dropping cyc
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    rdv1 <= 1'b0;
                    ack2 <= 1'b0;
                    err2 <= 1'b0;
                    rd2  <= '0;
                end else begin
                    rdv1 <= wb_cyc_i[p] & accept[p] & ~wb_we_i[p] & ~oob[p];
                    ack2 <= wb_cyc_i[p] & ack1;
                    err2 <= wb_cyc_i[p] & err1;
                    if (rdv1 && wb_cyc_i[p]) begin
                        rd2 <= rd1;
                    end
                end
            end

            assign wb_ack_o[p] = ack2;
            assign wb_err_o[p] = err2;
            assign wb_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = rd2;
        end else begin : g_lat1
            assign wb_ack_o[p] = ack1;
            assign wb_err_o[p] = err1;
            assign wb_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = rd1;
        end
    end

endmodule
